cgra_mem_bank_ctrl: RTL and testbench

- Per-bank controller in front of one CGRA SRAM bank wrapper (single-port, 1-cycle read latency, active-high retention request).
- Arbitrates two requesters onto the bank: port 0 is the host bus, port 1 is the CGRA load/store unit.
- Manages idle-driven retention entry and timed wake-up, so the bank sits in retention when unused and no access is ever issued while it is retentive.

---
 rtl/cgra_mem_bank_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cgra_mem_bank_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_mem_bank_ctrl.sv
// cgra_mem_bank_ctrl: controller in front of one single-port CGRA SRAM bank.
// Arbitrates the host bus (port 0) and the CGRA load/store unit (port 1) onto
// the bank, and parks the bank in retention after a run of idle cycles, waking
// it on demand before any access is issued.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   retention_en_i                software enable for automatic retention
//   p_req_i/we/addr/wdata/be      per-port request payload (held until granted)
//   p_gnt_o                       per-port grant, combinational in the request cycle
//   p_rvalid_o, p_rdata_o         per-port response valid, shared read data
//   mem_*_o, mem_rdata_i          bank interface (1-cycle read latency)
//   mem_set_retentive_o           bank retention request, active high
//   retentive_o                   status: bank is retentive or still waking
module cgra_mem_bank_ctrl #(
  parameter  int unsigned NumWords   = 1024,
  parameter  int unsigned IdleCycles = 16,
  parameter  int unsigned WakeCycles = 2,
  localparam int unsigned AddrWidth  = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      retention_en_i,
  input  logic [1:0]                p_req_i,
  input  logic [1:0]                p_we_i,
  input  logic [1:0][AddrWidth-1:0] p_addr_i,
  input  logic [1:0][31:0]          p_wdata_i,
  input  logic [1:0][3:0]           p_be_i,
  output logic [1:0]                p_gnt_o,
  output logic [1:0]                p_rvalid_o,
  output logic [31:0]               p_rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [AddrWidth-1:0]      mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  output logic [3:0]                mem_be_o,
  output logic                      mem_set_retentive_o,
  input  logic [31:0]               mem_rdata_i,
  output logic                      retentive_o
);

  localparam int unsigned IdleW = (IdleCycles > 1) ? $clog2(IdleCycles) : 1;
  localparam int unsigned WakeW = $clog2(WakeCycles + 1);

  localparam logic [1:0] ST_ACTIVE    = 2'd0;
  localparam logic [1:0] ST_RETENTIVE = 2'd1;
  localparam logic [1:0] ST_WAKE      = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [WakeW-1:0] wake_q, wake_d;
  logic             last_q, last_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic             rd_q, rd_d;

  logic       any_req;
  logic       grant_en;
  logic       winner;
  logic [1:0] gnt_c;
  logic       gnt_any;

  assign any_req = |p_req_i;

  // Grants are held off during reset so every output is quiet while rst_ni is low.
  assign grant_en = rst_ni && (state_q == ST_ACTIVE);

  // Power-state sequencing: idle run-length count, retention, timed wake-up.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    case (state_q)
      ST_ACTIVE: begin
        if (any_req || !retention_en_i) begin
          idle_d = '0;
        end else if (idle_q == IdleW'(IdleCycles - 1)) begin
          // A grant always clears the counter, so with IdleCycles >= 2 no
          // response can still be in flight when this branch is taken.
          idle_d  = '0;
          state_d = ST_RETENTIVE;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
      ST_RETENTIVE: begin
        idle_d = '0;
        if (any_req || !retention_en_i) begin
          state_d = ST_WAKE;
          wake_d  = WakeW'(WakeCycles);
        end
      end
      ST_WAKE: begin
        idle_d = '0;
        if (wake_q <= WakeW'(1)) begin
          // Counter reaches 0 on entry to ACTIVE, the first grantable cycle.
          wake_d  = '0;
          state_d = ST_ACTIVE;
        end else begin
          wake_d = wake_q - WakeW'(1);
        end
      end
      default: begin
        state_d = ST_ACTIVE;
        idle_d  = '0;
        wake_d  = '0;
      end
    endcase
  end

  // Round-robin between two ports: on a tie the port not granted last wins.
  always_comb begin
    gnt_c  = 2'b00;
    winner = 1'b0;
    if (grant_en) begin
      case (p_req_i)
        2'b01: begin
          winner = 1'b0;
          gnt_c  = 2'b01;
        end
        2'b10: begin
          winner = 1'b1;
          gnt_c  = 2'b10;
        end
        2'b11: begin
          winner = ~last_q;
          gnt_c  = winner ? 2'b10 : 2'b01;
        end
        default: begin
          winner = 1'b0;
          gnt_c  = 2'b00;
        end
      endcase
    end
  end

  assign gnt_any = |gnt_c;

  // Response tracking: one rvalid per grant, one cycle later.
  always_comb begin
    last_d   = gnt_any ? winner : last_q;
    rvalid_d = gnt_c;
    rd_d     = gnt_any && !p_we_i[winner];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_ACTIVE;
      idle_q   <= '0;
      wake_q   <= '0;
      last_q   <= 1'b1;
      rvalid_q <= 2'b00;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      wake_q   <= wake_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      rd_q     <= rd_d;
    end
  end

  // Bank drive: winner's payload on a grant, all zero otherwise.
  assign p_gnt_o     = gnt_c;
  assign mem_req_o   = gnt_any;
  assign mem_we_o    = gnt_any ? p_we_i[winner]    : 1'b0;
  assign mem_addr_o  = gnt_any ? p_addr_i[winner]  : '0;
  assign mem_wdata_o = gnt_any ? p_wdata_i[winner] : '0;
  assign mem_be_o    = gnt_any ? p_be_i[winner]    : '0;

  assign p_rvalid_o  = rvalid_q;
  assign p_rdata_o   = rd_q ? mem_rdata_i : '0;

  assign mem_set_retentive_o = (state_q == ST_RETENTIVE);
  assign retentive_o         = (state_q != ST_ACTIVE);

endmodule

// File: tb/tb_cgra_mem_bank_ctrl.sv
// tb_cgra_mem_bank_ctrl: directed bench for cgra_mem_bank_ctrl. Grants and bank
// drive are checked in the issuing cycle; responses go through a scoreboard
// queue that a forked monitor drains on every p_rvalid_o.
module tb_cgra_mem_bank_ctrl;

  localparam int unsigned AW = 10;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                retention_en_i;
  logic [1:0]          p_req_i;
  logic [1:0]          p_we_i;
  logic [1:0][AW-1:0]  p_addr_i;
  logic [1:0][31:0]    p_wdata_i;
  logic [1:0][3:0]     p_be_i;
  logic [1:0]          p_gnt_o;
  logic [1:0]          p_rvalid_o;
  logic [31:0]         p_rdata_o;
  logic                mem_req_o;
  logic                mem_we_o;
  logic [AW-1:0]       mem_addr_o;
  logic [31:0]         mem_wdata_o;
  logic [3:0]          mem_be_o;
  logic                mem_set_retentive_o;
  logic [31:0]         mem_rdata_i;
  logic                retentive_o;

  cgra_mem_bank_ctrl dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .retention_en_i      (retention_en_i),
    .p_req_i             (p_req_i),
    .p_we_i              (p_we_i),
    .p_addr_i            (p_addr_i),
    .p_wdata_i           (p_wdata_i),
    .p_be_i              (p_be_i),
    .p_gnt_o             (p_gnt_o),
    .p_rvalid_o          (p_rvalid_o),
    .p_rdata_o           (p_rdata_o),
    .mem_req_o           (mem_req_o),
    .mem_we_o            (mem_we_o),
    .mem_addr_o          (mem_addr_o),
    .mem_wdata_o         (mem_wdata_o),
    .mem_be_o            (mem_be_o),
    .mem_set_retentive_o (mem_set_retentive_o),
    .mem_rdata_i         (mem_rdata_i),
    .retentive_o         (retentive_o)
  );

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_rsp(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.due  = cyc + 1;
    sbq.push_back(e);
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({p_gnt_o, p_rvalid_o, p_rdata_o, mem_req_o, mem_we_o, mem_addr_o,
                 mem_wdata_o, mem_be_o, mem_set_retentive_o, retentive_o});
  endfunction

  // Response monitor plus retention-safety assertion, sampled mid-cycle.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (mem_set_retentive_o) begin
        checks++;
        assert (p_rvalid_o == 2'b00 && !mem_req_o && p_gnt_o == 2'b00)
        else begin
          errors++;
          $display("FAIL retention_safety: rvalid=%b req=%b gnt=%b expected all 0", p_rvalid_o, mem_req_o, p_gnt_o);
        end
      end
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_rvalid: no rvalid observed, expected port %0d at cycle %0d", e.port, e.due);
      end
      if (p_rvalid_o != 2'b00) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got %b expected 00 (cycle %0d)", p_rvalid_o, cyc);
        end else begin
          e = sbq.pop_front();
          chk("rvalid_port", p_rvalid_o, 2'b01 << e.port);
          chk("rdata", p_rdata_o, e.data);
          chk("rvalid_cycle", cyc, e.due);
        end
      end
    end
  endtask

  // From an idle cycle with retention enabled: 16 idle cycles, then retentive.
  task automatic wait_retention(input string tag);
    for (int j = 0; j < 16; j++) begin
      #1;
      chk({tag, "_not_yet_ret"}, mem_set_retentive_o, 1'b0);
      next_cyc();
    end
    #1;
    chk({tag, "_set_ret"}, mem_set_retentive_o, 1'b1);
    chk({tag, "_retentive"}, retentive_o, 1'b1);
  endtask

  initial begin
    logic bad;
    rst_ni         = 1'b0;
    retention_en_i = 1'b0;
    p_req_i        = 2'b00;
    p_we_i         = 2'b00;
    p_addr_i       = '0;
    p_wdata_i      = '0;
    p_be_i         = '0;
    mem_rdata_i    = '0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outs", all_outs(), 128'd0);
    rst_ni = 1'b1;

    // Port 0 read
    next_cyc();
    p_req_i     = 2'b01;
    p_addr_i[0] = 10'h005;
    mem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("t1_gnt", p_gnt_o, 2'b01);
    chk("t1_addr", mem_addr_o, 10'h005);
    chk("t1_req_we", {mem_req_o, mem_we_o}, 2'b10);
    push_rsp(1'b0, 32'hDEADBEEF);
    next_cyc();
    p_req_i = 2'b00;

    // Port 1 write
    next_cyc();
    p_req_i      = 2'b10;
    p_we_i       = 2'b10;
    p_addr_i[1]  = 10'h3FF;
    p_wdata_i[1] = 32'h12345678;
    p_be_i[1]    = 4'b0011;
    #1;
    chk("t3_gnt", p_gnt_o, 2'b10);
    chk("t3_req_we", {mem_req_o, mem_we_o}, 2'b11);
    chk("t3_addr", mem_addr_o, 10'h3FF);
    chk("t3_wdata", mem_wdata_o, 32'h12345678);
    chk("t3_be", mem_be_o, 4'b0011);
    push_rsp(1'b1, 32'h0);
    next_cyc();
    p_req_i = 2'b00;
    p_we_i  = 2'b00;

    // Both ports contend for 4 cycles (port 1 was last granted)
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      mem_rdata_i = 32'h1000_0000 + 32'(i);
      p_req_i     = 2'b11;
      p_addr_i[0] = 10'h010;
      p_addr_i[1] = 10'h020;
      #1;
      chk("t2_gnt", p_gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_addr", mem_addr_o, (i % 2 == 0) ? 10'h010 : 10'h020);
      push_rsp((i % 2) != 0, 32'h1000_0001 + 32'(i));
    end
    next_cyc();
    p_req_i        = 2'b00;
    mem_rdata_i    = 32'h1000_0004;
    retention_en_i = 1'b1;

    // Idle entry into retention, then wake on a port 0 request
    wait_retention("t4");
    next_cyc();
    #1;
    chk("t4_hold_ret", {mem_set_retentive_o, p_gnt_o}, 3'b100);
    next_cyc();
    p_req_i     = 2'b01;
    p_addr_i[0] = 10'h0AA;
    mem_rdata_i = 32'h0BADF00D;
    #1;
    chk("t4_no_gnt_ret", {p_gnt_o, mem_req_o, mem_set_retentive_o}, 4'b0001);
    next_cyc();
    #1;
    chk("t4_wake1", {mem_set_retentive_o, retentive_o, p_gnt_o}, 4'b0100);
    next_cyc();
    #1;
    chk("t4_wake2", {mem_set_retentive_o, retentive_o, p_gnt_o}, 4'b0100);
    next_cyc();
    #1;
    chk("t4_gnt_after_wake", {retentive_o, p_gnt_o}, 3'b001);
    chk("t4_addr", mem_addr_o, 10'h0AA);
    push_rsp(1'b0, 32'h0BADF00D);
    next_cyc();
    p_req_i        = 2'b00;
    retention_en_i = 1'b0;

    // Retention disabled: 100 idle cycles never retentive
    bad = 1'b0;
    for (int k = 0; k < 100; k++) begin
      next_cyc();
      #1;
      if (retentive_o || mem_set_retentive_o) bad = 1'b1;
    end
    chk("t5_never_ret", bad, 1'b0);
    retention_en_i = 1'b1;
    wait_retention("t5");
    next_cyc();
    retention_en_i = 1'b0;
    #1;
    chk("t5_still_ret", mem_set_retentive_o, 1'b1);
    next_cyc();
    #1;
    chk("t5_wake1", {mem_set_retentive_o, retentive_o}, 2'b01);
    next_cyc();
    #1;
    chk("t5_wake2", {mem_set_retentive_o, retentive_o}, 2'b01);
    next_cyc();
    #1;
    chk("t5_active", {mem_set_retentive_o, retentive_o}, 2'b00);

    // Reset right after a read grant: response discarded, pointer restored
    next_cyc();
    p_req_i     = 2'b01;
    p_we_i      = 2'b00;
    p_addr_i[0] = 10'h007;
    #1;
    chk("t6_gnt", p_gnt_o, 2'b01);
    #2;
    rst_ni  = 1'b0;
    p_req_i = 2'b11;
    #1;
    chk("t6_in_reset_outs", all_outs(), 128'd0);
    next_cyc();
    #1;
    chk("t6_reset_no_rvalid", all_outs(), 128'd0);
    next_cyc();
    rst_ni      = 1'b1;
    p_req_i     = 2'b11;
    p_addr_i[0] = 10'h011;
    p_addr_i[1] = 10'h022;
    mem_rdata_i = 32'h600D0001;
    #1;
    chk("t6_first_tie", p_gnt_o, 2'b01);
    push_rsp(1'b0, 32'h600D0001);
    next_cyc();
    p_req_i = 2'b10;
    #1;
    chk("t6_second", p_gnt_o, 2'b10);
    push_rsp(1'b1, 32'h600D0002);
    next_cyc();
    p_req_i     = 2'b00;
    mem_rdata_i = 32'h600D0002;
    repeat (3) next_cyc();
    chk("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
